// File: rtl/dmac_fifo_ctrl_pkg.sv
// dmac_fifo_ctrl_pkg
// Shared definitions for the DMA FIFO controller slice.
//   op_t        : operation / state codes. The low five codes are the values
//                 visible on the `state` output. CLEAR is internal only and
//                 never reaches the state register.
//   DEPTH       : number of storage entries
//   PTR_W/CNT_W : pointer and occupancy widths
package dmac_fifo_ctrl_pkg;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    WRITE    = 3'b001,
    READ     = 3'b010,
    WR_ERROR = 3'b011,
    RD_ERROR = 3'b100,
    CLEAR    = 3'b101
  } op_t;

endpackage

// File: rtl/dmac_fifo_ctrl_if.sv
// dmac_fifo_ctrl_if
// Request/status bundle between a FIFO user and the controller.
//   clear, wr_en, rd_en      : requests from the user (master drives)
//   we, re, wr_addr, rd_addr : storage strobes and indices
//   state, data_count        : registered last-operation code and occupancy
//   full, empty              : occupancy flags
//   wr_ack, wr_err, rd_ack, rd_err : one-cycle status pulses
interface dmac_fifo_ctrl_if;
  import dmac_fifo_ctrl_pkg::*;

  logic             clear;
  logic             wr_en;
  logic             rd_en;
  logic             we;
  logic             re;
  logic [PTR_W-1:0] wr_addr;
  logic [PTR_W-1:0] rd_addr;
  logic [2:0]       state;
  logic [CNT_W-1:0] data_count;
  logic             full;
  logic             empty;
  logic             wr_ack;
  logic             wr_err;
  logic             rd_ack;
  logic             rd_err;

  modport master (
    output clear, wr_en, rd_en,
    input  we, re, wr_addr, rd_addr, state, data_count, full, empty,
    input  wr_ack, wr_err, rd_ack, rd_err
  );

  modport slave (
    input  clear, wr_en, rd_en,
    output we, re, wr_addr, rd_addr, state, data_count, full, empty,
    output wr_ack, wr_err, rd_ack, rd_err
  );

endinterface

// File: rtl/dmac_fifo_next.sv
// dmac_fifo_next
// Purely combinational next-state arithmetic for the FIFO pointers.
//   op                : operation selected this cycle
//   head, tail, count : current registered values
//   head_next, tail_next, count_next : values to load at the next edge
//   we, re            : storage strobes for this cycle
// Pointers are PTR_W bits wide, so the 7 -> 0 wrap falls out of the add.
module dmac_fifo_next
  import dmac_fifo_ctrl_pkg::*;
(
  input  op_t              op,
  input  logic [PTR_W-1:0] head,
  input  logic [PTR_W-1:0] tail,
  input  logic [CNT_W-1:0] count,
  output logic [PTR_W-1:0] head_next,
  output logic [PTR_W-1:0] tail_next,
  output logic [CNT_W-1:0] count_next,
  output logic             we,
  output logic             re
);

  // Hold everything by default; only WRITE, READ and CLEAR move state.
  always_comb begin
    head_next  = head;
    tail_next  = tail;
    count_next = count;
    we         = 1'b0;
    re         = 1'b0;
    case (op)
      WRITE: begin
        we         = 1'b1;
        tail_next  = tail + PTR_W'(1);
        count_next = count + CNT_W'(1);
      end
      READ: begin
        re         = 1'b1;
        head_next  = head + PTR_W'(1);
        count_next = count - CNT_W'(1);
      end
      CLEAR: begin
        head_next  = '0;
        tail_next  = '0;
        count_next = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmac_fifo_ctrl.sv
// dmac_fifo_ctrl
// Pointer/occupancy controller for an 8-entry FIFO.
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-high reset
//   bus   : dmac_fifo_ctrl_if.slave carrying requests, strobes, indices,
//           state, count, flags and status pulses
// Owns operation selection, the registers and the full/empty decode; the
// pointer arithmetic lives in dmac_fifo_next.
module dmac_fifo_ctrl
  import dmac_fifo_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  dmac_fifo_ctrl_if.slave  bus
);

  op_t              op;
  op_t              state_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] head_next;
  logic [PTR_W-1:0] tail_next;
  logic [CNT_W-1:0] count_next;
  logic             full;
  logic             empty;
  logic             wr_ack_q;
  logic             wr_err_q;
  logic             rd_ack_q;
  logic             rd_err_q;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Priority select. Reset forces IDLE so no strobe leaks out while the
  // registers are being held; a write request masks any read request.
  always_comb begin
    op = IDLE;
    if (reset) begin
      op = IDLE;
    end else if (bus.clear) begin
      op = CLEAR;
    end else if (bus.wr_en) begin
      op = full ? WR_ERROR : WRITE;
    end else if (bus.rd_en) begin
      op = empty ? RD_ERROR : READ;
    end
  end

  dmac_fifo_next u_next (
    .op         (op),
    .head       (head_q),
    .tail       (tail_q),
    .count      (count_q),
    .head_next  (head_next),
    .tail_next  (tail_next),
    .count_next (count_next),
    .we         (bus.we),
    .re         (bus.re)
  );

  // State register and status pulses. CLEAR reports as IDLE; each pulse is
  // recomputed every edge so it lasts exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      head_q   <= head_next;
      tail_q   <= tail_next;
      count_q  <= count_next;
      state_q  <= (op == CLEAR) ? IDLE : op;
      wr_ack_q <= (op == WRITE);
      wr_err_q <= (op == WR_ERROR);
      rd_ack_q <= (op == READ);
      rd_err_q <= (op == RD_ERROR);
    end
  end

  assign bus.wr_addr    = tail_q;
  assign bus.rd_addr    = head_q;
  assign bus.state      = state_q;
  assign bus.data_count = count_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.rd_ack     = rd_ack_q;
  assign bus.rd_err     = rd_err_q;

endmodule

// File: tb/tb_dmac_fifo_ctrl.sv
// tb_dmac_fifo_ctrl
// Directed bench for dmac_fifo_ctrl: fill, overflow, drain with wrap,
// simultaneous request, clear, and reset in the middle of a write burst.
// Inputs change on the falling edge; combinational strobes are checked 1ns
// later and registered outputs 1ns after the rising edge.
module tb_dmac_fifo_ctrl;

  logic clk;
  logic reset;
  int   checkCount;
  int   errorCount;

  dmac_fifo_ctrl_if bus ();

  dmac_fifo_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive the three request inputs just after a falling edge, then settle.
  task automatic applyStimulus(input logic clr, input logic wr, input logic rd);
    @(negedge clk);
    bus.clear = clr;
    bus.wr_en = wr;
    bus.rd_en = rd;
    #1;
  endtask

  // Advance past the next rising edge so registered outputs can be read.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset      = 1'b1;
    bus.clear  = 1'b0;
    bus.wr_en  = 1'b1;
    bus.rd_en  = 1'b0;
    #2;

    // Reset state, with a write request already pending.
    $display("[TB] reset");
    checkOutput("rst_count", 32'(bus.data_count), 32'd0);
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_we", 32'(bus.we), 32'd0);
    checkOutput("rst_state", 32'(bus.state), 32'd0);
    checkOutput("rst_wr_ack", 32'(bus.wr_ack), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Fill: eight writes, addresses 0..7, ack after each.
    $display("[TB] fill");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("fill_we", 32'(bus.we), 32'd1);
      checkOutput("fill_re", 32'(bus.re), 32'd0);
      checkOutput("fill_wr_addr", 32'(bus.wr_addr), 32'(i));
      tick();
      checkOutput("fill_wr_ack", 32'(bus.wr_ack), 32'd1);
      checkOutput("fill_count", 32'(bus.data_count), 32'(i + 1));
    end
    checkOutput("fill_full", 32'(bus.full), 32'd1);
    checkOutput("fill_state", 32'(bus.state), 32'd1);

    // Overflow: write while full is rejected.
    $display("[TB] overflow");
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("ovf_we", 32'(bus.we), 32'd0);
    tick();
    checkOutput("ovf_wr_err", 32'(bus.wr_err), 32'd1);
    checkOutput("ovf_wr_ack", 32'(bus.wr_ack), 32'd0);
    checkOutput("ovf_state", 32'(bus.state), 32'd3);
    checkOutput("ovf_count", 32'(bus.data_count), 32'd8);

    // Drain: eight reads then one underflow; head wraps back to 0.
    $display("[TB] drain");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("drain_re", 32'(bus.re), 32'd1);
      checkOutput("drain_we", 32'(bus.we), 32'd0);
      checkOutput("drain_rd_addr", 32'(bus.rd_addr), 32'(i));
      tick();
      checkOutput("drain_rd_ack", 32'(bus.rd_ack), 32'd1);
      checkOutput("drain_count", 32'(bus.data_count), 32'(7 - i));
    end
    checkOutput("drain_wr_err_gone", 32'(bus.wr_err), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("udf_re", 32'(bus.re), 32'd0);
    tick();
    checkOutput("udf_rd_err", 32'(bus.rd_err), 32'd1);
    checkOutput("udf_rd_ack", 32'(bus.rd_ack), 32'd0);
    checkOutput("udf_state", 32'(bus.state), 32'd4);
    checkOutput("udf_empty", 32'(bus.empty), 32'd1);
    checkOutput("udf_rd_addr_wrap", 32'(bus.rd_addr), 32'd0);

    // Simultaneous request at count 3: write wins, read dropped silently.
    $display("[TB] simultaneous");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick();
    end
    checkOutput("sim_pre_count", 32'(bus.data_count), 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("sim_we", 32'(bus.we), 32'd1);
    checkOutput("sim_re", 32'(bus.re), 32'd0);
    checkOutput("sim_wr_addr", 32'(bus.wr_addr), 32'd3);
    tick();
    checkOutput("sim_count", 32'(bus.data_count), 32'd4);
    checkOutput("sim_rd_err", 32'(bus.rd_err), 32'd0);
    checkOutput("sim_rd_ack", 32'(bus.rd_ack), 32'd0);
    checkOutput("sim_state", 32'(bus.state), 32'd1);

    // Build head=2, count=5 (tail=7), then clear together with a write.
    $display("[TB] clear");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick();
    end
    checkOutput("clr_pre_count", 32'(bus.data_count), 32'd5);
    checkOutput("clr_pre_head", 32'(bus.rd_addr), 32'd2);
    checkOutput("clr_pre_tail", 32'(bus.wr_addr), 32'd7);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("clr_we", 32'(bus.we), 32'd0);
    tick();
    checkOutput("clr_head", 32'(bus.rd_addr), 32'd0);
    checkOutput("clr_tail", 32'(bus.wr_addr), 32'd0);
    checkOutput("clr_count", 32'(bus.data_count), 32'd0);
    checkOutput("clr_state", 32'(bus.state), 32'd0);
    checkOutput("clr_wr_ack", 32'(bus.wr_ack), 32'd0);

    // Reset asserted between edges during a write burst.
    $display("[TB] reset mid-burst");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick();
    end
    checkOutput("mid_pre_count", 32'(bus.data_count), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("mid_pre_we", 32'(bus.we), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_count", 32'(bus.data_count), 32'd0);
    checkOutput("mid_we", 32'(bus.we), 32'd0);
    checkOutput("mid_wr_addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("mid_empty", 32'(bus.empty), 32'd1);
    checkOutput("mid_wr_ack", 32'(bus.wr_ack), 32'd0);
    checkOutput("mid_state", 32'(bus.state), 32'd0);
    tick();
    checkOutput("mid_hold_count", 32'(bus.data_count), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("post_we", 32'(bus.we), 32'd1);
    checkOutput("post_wr_addr", 32'(bus.wr_addr), 32'd0);
    tick();
    checkOutput("post_count", 32'(bus.data_count), 32'd1);
    checkOutput("post_wr_ack", 32'(bus.wr_ack), 32'd1);

    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("idle_wr_ack", 32'(bus.wr_ack), 32'd0);
    checkOutput("idle_state", 32'(bus.state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
